// File: rtl/bch15_pkg.sv
// Shared definitions for the BCH(15,7) double-error-correcting decoder.
// GF(16) in polynomial basis, p(x) = x^4 + x + 1, alpha = 4'b0010.
package bch15_pkg;

  localparam int         GF_M      = 4;
  localparam int         N         = 15;
  localparam int         K         = 7;
  localparam logic [4:0] PRIM_POLY = 5'b10011;

  // Per-position Chien update factors: alpha^-1 and alpha^-2.
  localparam logic [3:0] A_INV1 = 4'b1001;  // a^14
  localparam logic [3:0] A_INV2 = 4'b1101;  // a^13

  typedef enum logic [2:0] {IDLE, SYND, ELP, CHIEN, DONE} state_t;

  // Carry-less multiply, then reduce the high bits by p(x).
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'(PRIM_POLY) << (i - 4));
    return p[3:0];
  endfunction

  // Inverse of a^k is a^(15-k). Zero maps to zero and is never consumed.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    case (a)
      4'h1: return 4'h1;  4'h2: return 4'h9;  4'h4: return 4'hD;  4'h8: return 4'hF;
      4'h3: return 4'hE;  4'h6: return 4'h7;  4'hC: return 4'hA;  4'hB: return 4'h5;
      4'h5: return 4'hB;  4'hA: return 4'hC;  4'h7: return 4'h6;  4'hE: return 4'h3;
      4'hF: return 4'h8;  4'hD: return 4'h4;  4'h9: return 4'h2;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] gf16_cube(input logic [3:0] a);
    return gf16_mul(gf16_mul(a, a), a);
  endfunction

endpackage

// File: rtl/bch15_chien_step.sv
// One Chien search position: tests 1 + t1 + t2 == 0 and advances the
// terms to the next position.
//   t1, t2           : sigma1*a^-idx, sigma2*a^-2idx
//   zero_hit         : locator evaluates to zero here (error at idx)
//   t1_next, t2_next : terms for idx+1
module bch15_chien_step
  import bch15_pkg::*;
(
  input  logic [GF_M-1:0] t1,
  input  logic [GF_M-1:0] t2,
  output logic            zero_hit,
  output logic [GF_M-1:0] t1_next,
  output logic [GF_M-1:0] t2_next
);

  assign zero_hit = ((4'h1 ^ t1 ^ t2) == 4'h0);
  assign t1_next  = gf16_mul(t1, A_INV1);
  assign t2_next  = gf16_mul(t2, A_INV2);

endmodule

// File: rtl/bch_syndromes.sv
// Combinational syndrome generator: s1 = r(alpha), s3 = r(alpha^3).
//   code : received word, bit i = coefficient of x^i
//   s1   : first syndrome
//   s3   : third syndrome
module bch_syndromes
  import bch15_pkg::*;
(
  input  logic [N-1:0]    code,
  output logic [GF_M-1:0] s1,
  output logic [GF_M-1:0] s3
);

  logic [GF_M-1:0] p1, p3;  // running alpha^i and alpha^3i

  always_comb begin
    s1 = '0;
    s3 = '0;
    p1 = 4'h1;
    p3 = 4'h1;
    for (int i = 0; i < N; i++) begin
      if (code[i]) begin
        s1 = s1 ^ p1;
        s3 = s3 ^ p3;
      end
      p1 = gf16_mul(p1, 4'h2);
      p3 = gf16_mul(p3, 4'h8);
    end
  end

endmodule

// File: rtl/bch15_dec_ctrl.sv
// Sequential BCH(15,7) t=2 decoder controller.
// Accepts one word, computes S1/S3, solves the locator in closed form,
// runs a serial Chien search (one position per cycle) and holds the result.
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_ready/in_code: received-word handshake (in_ready == IDLE)
//   out_valid/out_ready      : result handshake, result held until taken
//   out_code, out_data       : corrected word and its message bits [14:8]
//   out_err_cnt, out_uncorr  : corrected bit count, decoding failure flag
module bch15_dec_ctrl
  import bch15_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic [K-1:0] out_data,
  output logic [1:0]   out_err_cnt,
  output logic         out_uncorr
);

  state_t          state, state_n;
  logic [N-1:0]    rcv, orig;
  logic [GF_M-1:0] s1, s3, syn_s1, syn_s3;
  logic [GF_M-1:0] t1, t2, t1_n, t2_n;
  logic [3:0]      idx, roots, root_total;
  logic [1:0]      deg;
  logic            unc_flag, hit, early;
  logic [N-1:0]    rcv_fixed;

  // Closed-form locator results
  logic [GF_M-1:0] s1_cube, sig1_c, sig2_c;
  logic [1:0]      deg_c;
  logic            unc_c;

  bch_syndromes u_synd (.code(rcv), .s1(syn_s1), .s3(syn_s3));

  bch15_chien_step u_step (
    .t1(t1), .t2(t2), .zero_hit(hit), .t1_next(t1_n), .t2_next(t2_n)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_code[N-1:N-K];

  // The zero-syndrome decision uses the registered syndromes, so the exit
  // is taken out of the cycle following SYND (2-cycle latency).
  assign early = EARLY_EXIT && (s1 == 4'h0) && (s3 == 4'h0);

  assign rcv_fixed  = hit ? (rcv ^ (15'd1 << idx)) : rcv;
  assign root_total = roots + {3'b000, hit};

  always_comb begin
    s1_cube = gf16_cube(s1);
    sig1_c  = s1;
    sig2_c  = '0;
    deg_c   = 2'd0;
    unc_c   = 1'b0;
    if (s1 == 4'h0) begin
      // Zero locator never hits, so an S3-only syndrome flips nothing.
      sig1_c = '0;
      unc_c  = (s3 != 4'h0);
    end else if (s3 == s1_cube) begin
      deg_c = 2'd1;
    end else begin
      sig2_c = gf16_mul(s3 ^ s1_cube, gf16_inv(s1));
      deg_c  = 2'd2;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = SYND;
      SYND:    state_n = ELP;
      ELP:     state_n = early ? DONE : CHIEN;
      CHIEN:   if (idx == 4'd14) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv         <= '0;
      orig        <= '0;
      s1          <= '0;
      s3          <= '0;
      t1          <= '0;
      t2          <= '0;
      idx         <= '0;
      roots       <= '0;
      deg         <= '0;
      unc_flag    <= 1'b0;
      out_code    <= '0;
      out_err_cnt <= '0;
      out_uncorr  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rcv  <= in_code;
          orig <= in_code;
        end
        SYND: begin
          s1 <= syn_s1;
          s3 <= syn_s3;
        end
        ELP: begin
          t1       <= sig1_c;
          t2       <= sig2_c;
          deg      <= deg_c;
          unc_flag <= unc_c;
          idx      <= '0;
          roots    <= '0;
          if (early) begin
            out_code    <= rcv;
            out_err_cnt <= 2'd0;
            out_uncorr  <= 1'b0;
          end
        end
        CHIEN: begin
          rcv   <= rcv_fixed;
          roots <= root_total;
          t1    <= t1_n;
          t2    <= t2_n;
          idx   <= idx + 4'd1;
          if (idx == 4'd14) begin
            // Root count disagreeing with the locator degree means more
            // than two errors: hand back the untouched word.
            if (unc_flag || (root_total != {2'b00, deg})) begin
              out_code    <= orig;
              out_err_cnt <= 2'd0;
              out_uncorr  <= 1'b1;
            end else begin
              out_code    <= rcv_fixed;
              out_err_cnt <= deg;
              out_uncorr  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch15_dec_ctrl.sv
module tb_bch15_dec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic [6:0]  out_data;
  logic [1:0]  out_err_cnt;
  logic        out_uncorr;

  int checks = 0;
  int fails  = 0;

  int alog [0:14];
  int lg   [0:15];

  bch15_dec_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_data(out_data), .out_err_cnt(out_err_cnt),
    .out_uncorr(out_uncorr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (log/antilog arithmetic) ----------------
  function automatic int fmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 15];
  endfunction

  function automatic int fdiv(input int a, input int b);
    if (a == 0) return 0;
    return alog[(lg[a] - lg[b] + 15) % 15];
  endfunction

  task automatic ref_decode(input logic [14:0] w, output logic [14:0] code,
                            output int errs, output logic unc, output int lat);
    int s1 = 0, s3 = 0, c3, sig1, sig2, deg, cnt, x, v;
    logic [14:0] fixed;
    for (int i = 0; i < 15; i++)
      if (w[i]) begin
        s1 ^= alog[i];
        s3 ^= alog[(3 * i) % 15];
      end
    code = w; errs = 0; unc = 1'b0; lat = 17;
    if (s1 == 0 && s3 == 0) begin
      lat = 2;
      return;
    end
    if (s1 == 0) begin
      unc = 1'b1;
      return;
    end
    c3   = fmul(fmul(s1, s1), s1);
    sig1 = s1;
    sig2 = fdiv(s3 ^ c3, s1);
    deg  = (sig2 == 0) ? 1 : 2;
    fixed = w; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      x = alog[(15 - i) % 15];
      v = 1 ^ fmul(sig1, x) ^ fmul(sig2, fmul(x, x));
      if (v == 0) begin
        fixed[i] = ~fixed[i];
        cnt++;
      end
    end
    if (cnt != deg) unc = 1'b1;
    else begin
      code = fixed;
      errs = deg;
    end
  endtask

  // ---------------- driver: one full transaction ----------------
  task automatic run_word(input logic [14:0] w, output logic [14:0] c,
                          output logic [1:0] e, output logic u,
                          output logic [6:0] d, output int lat);
    in_code = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    c = out_code; e = out_err_cnt; u = out_uncorr; d = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_code !== 15'h0) begin fails++; $display("FAIL reset_out_code got %h want 0000", out_code); end
    checks++; if (out_err_cnt !== 2'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", out_err_cnt); end
    checks++; if (out_uncorr !== 1'b0) begin fails++; $display("FAIL reset_uncorr got %b want 0", out_uncorr); end
  endtask

  task automatic test_vectors();
    logic [14:0] wv   [5] = '{15'h0000, 15'h0010, 15'h11D1, 15'h4001, 15'h0013};
    logic [14:0] ecode[5] = '{15'h0000, 15'h0000, 15'h01D1, 15'h0000, 15'h0013};
    int          eerr [5] = '{0, 1, 1, 2, 0};
    logic        eunc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          elat [5] = '{2, 17, 17, 17, 17};
    logic [14:0] c; logic [1:0] e; logic u; logic [6:0] d; int lat;
    logic [14:0] ec;
    for (int i = 0; i < 5; i++) begin
      run_word(wv[i], c, e, u, d, lat);
      ec = ecode[i];
      checks++; if (lat != elat[i]) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, elat[i]); end
      checks++; if (c !== ec) begin fails++; $display("FAIL vec%0d_code got %h want %h", i, c, ec); end
      checks++; if (d !== ec[14:8]) begin fails++; $display("FAIL vec%0d_data got %h want %h", i, d, ec[14:8]); end
      checks++; if (e !== 2'(eerr[i])) begin fails++; $display("FAIL vec%0d_err_cnt got %0d want %0d", i, e, eerr[i]); end
      checks++; if (u !== eunc[i]) begin fails++; $display("FAIL vec%0d_uncorr got %b want %b", i, u, eunc[i]); end
    end
  endtask

  task automatic test_hold();
    int lat = -1;
    in_code = 15'h0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    checks++; if (lat != 17) begin fails++; $display("FAIL hold_latency got %0d want 17", lat); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_code !== 15'h0 ||
          out_err_cnt !== 2'd1 || out_uncorr !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable cyc%0d got v=%b r=%b code=%h e=%0d u=%b want v=1 r=0 code=0000 e=1 u=0",
                 k, out_valid, in_ready, out_code, out_err_cnt, out_uncorr);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_chien();
    logic [14:0] c; logic [1:0] e; logic u; logic [6:0] d; int lat;
    in_code = 15'h4001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);  // now in CHIEN at idx 7
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_immediate got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_code !== 15'h0 || out_err_cnt !== 2'd0 || out_uncorr !== 1'b0) begin fails++; $display("FAIL midrst_outputs got code=%h e=%0d u=%b want 0000 0 0", out_code, out_err_cnt, out_uncorr); end
    run_word(15'h11D1, c, e, u, d, lat);
    checks++; if (lat != 17 || c !== 15'h01D1 || e !== 2'd1 || u !== 1'b0) begin fails++; $display("FAIL midrst_next_word got lat=%0d code=%h e=%0d u=%b want 17 01d1 1 0", lat, c, e, u); end
  endtask

  task automatic test_random();
    logic [14:0] g = 15'h01D1;
    logic [14:0] cw, w, c, rc; logic [1:0] e; logic u, ru; logic [6:0] d, msg;
    int lat, rerr, rlat, nerr, pos;
    for (int it = 0; it < 40; it++) begin
      msg = 7'($urandom_range(0, 127));
      cw = '0;
      for (int i = 0; i < 7; i++) if (msg[i]) cw ^= (g << i);
      w = cw;
      nerr = $urandom_range(0, 3);
      for (int k = 0; k < nerr; k++) begin
        pos = $urandom_range(0, 14);
        w[pos] = ~w[pos];
      end
      if (it % 8 == 7) w = 15'($urandom);
      ref_decode(w, rc, rerr, ru, rlat);
      run_word(w, c, e, u, d, lat);
      checks++;
      if (c !== rc || e !== 2'(rerr) || u !== ru || lat != rlat || d !== rc[14:8]) begin
        fails++;
        $display("FAIL rand%0d word=%h got code=%h e=%0d u=%b lat=%0d want code=%h e=%0d u=%b lat=%0d",
                 it, w, c, e, u, lat, rc, rerr, ru, rlat);
      end
    end
  endtask

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      alog[i] = v;
      lg[v]   = i;
      v = v << 1;
      if (v & 16) v ^= 5'h13;
    end
    lg[0] = 0;

    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_vectors();
    test_hold();
    test_reset_mid_chien();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
